vwb: RTL and testbench
======================

# vwb

Vector-lane writeback unit: the consuming end of the execution-stage-to-writeback interface. Accepts ALU/multiplier results from the lane's execution stage and returning load data, arbitrates them onto the single vector-register-file write port, resolves masked (undisturbed) writes, and enforces write-after-write order between a pending load and younger ALU results to the same register. ALU results are buffered in a small FIFO, with backpressure to the execution stage.

## Interface
- DATA_WIDTH, 64, lane data width in bits
- FIFO_DEPTH, 4, ALU-result buffer entries (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_write_back_enable  in  1  execution result valid this cycle
- ex_destination  in  5  destination vector register
- ex_result  in  DATA_WIDTH  computed result
- ex_masked_write_back  in  1  1 = element masked off, write ex_operand_3 instead of ex_result
- ex_sew  in  3  element width code, forwarded
- ex_operand_3  in  DATA_WIDTH  old destination value
- wait_load_signal  in  1  a load into load_destination has been issued
- load_destination  in  5  destination of that load
- ld_valid  in  1  load data returning this cycle
- ld_data  in  DATA_WIDTH  load data
- ex_stall  out  1  execution stage must not present a new result
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  DATA_WIDTH  write data
- rf_wsew  out  3  element width of the write
- load_pending  out  1  a load is outstanding
- err_protocol  out  1  sticky protocol-violation flag

## Operation
- Enqueue: ex_write_back_enable=1 pushes {ex_destination, data, ex_sew} into FIFO; data = ex_masked_write_back ? ex_operand_3 : ex_result (merge done at enqueue).
- Load tracker FSM, states IDLE and PENDING. IDLE: wait_load_signal=1 → PENDING, latch load_destination into pend_dest. PENDING: ld_valid=1 → write {pend_dest, ld_data, sew=3} and go to IDLE; if wait_load_signal=1 in the same cycle, latch the new destination and stay PENDING.
- Write-port arbitration per cycle, priority: (1) load write, (2) FIFO head. Head is blocked while PENDING and head destination == pend_dest (WAW); head-of-line blocking applies to all younger entries.
- ex_stall = FIFO occupancy ≥ FIFO_DEPTH−1 (combinational), leaving room for one in-flight beat.
- err_protocol set (sticky until rst) on: push while FIFO full (entry dropped); ld_valid in IDLE (data dropped); wait_load_signal in PENDING without ld_valid the same cycle (new request ignored).
- Simultaneous push and pop on a full FIFO: pop first, push accepted, no error.

## Timing
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, rf_wsew=0, load_pending=0, err_protocol=0, ex_stall=0, FIFO empty, FSM IDLE. rst mid-operation discards all queued entries and any pending load.
- rf_* are registered. Load data sampled at edge k → rf_we=1 in cycle following edge k (1-cycle latency, never delayed).
- ALU result sampled at edge k → earliest rf_we at edge k+1 (2-stage: FIFO, output register), unless bypass enabled.
- One FIFO pop per cycle max; rf_we deasserts the cycle after the last write.
- load_pending reflects FSM state registered (1 from edge after wait_load_signal).

## Configuration
- VWB_BYPASS_EN defined: when FIFO empty, no load write this cycle, and no WAW block on the incoming result, the incoming result loads the output register directly at edge k (rf_we cycle after edge k), FIFO not touched.
- Undefined: every ALU result passes through the FIFO; minimum latency one cycle longer. Functional order identical in both.

## Test plan
- Single ALU result dest=3, result=0xAA, masked=0 → rf_we once, rf_waddr=3, rf_wdata=0xAA, 2 cycles later (1 with VWB_BYPASS_EN).
- Masked write dest=5, result=0x11, operand_3=0x22, masked=1 → rf_wdata=0x22.
- wait_load dest=7, then ALU result dest=7 (0x55), ld_valid 3 cycles later ld_data=0x99 → write 0x99 to v7 first, then 0x55 to v7 next cycle.
- Load returning same cycle as FIFO head dest=2 ready → load written first, head written next cycle; no loss.
- Push 4 back-to-back results while PENDING blocks head → ex_stall rises at occupancy 3; fifth push when full sets err_protocol, entry dropped.
- ld_valid with no pending load → no rf_we, err_protocol=1; rst clears it to 0.

Source files
------------

// File: rtl/vwb_if.sv
// Execution-stage / load-return to writeback bundle for the vwb lane writeback unit.
// master = producers (execution stage, load unit), slave = vwb.
interface vwb_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  ex_write_back_enable;
    logic [4:0]            ex_destination;
    logic [DATA_WIDTH-1:0] ex_result;
    logic                  ex_masked_write_back;
    logic [2:0]            ex_sew;
    logic [DATA_WIDTH-1:0] ex_operand_3;
    logic                  wait_load_signal;
    logic [4:0]            load_destination;
    logic                  ld_valid;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ex_stall;
    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [2:0]            rf_wsew;
    logic                  load_pending;
    logic                  err_protocol;

    modport master (
        output ex_write_back_enable, ex_destination, ex_result, ex_masked_write_back,
               ex_sew, ex_operand_3, wait_load_signal, load_destination, ld_valid, ld_data,
        input  ex_stall, rf_we, rf_waddr, rf_wdata, rf_wsew, load_pending, err_protocol
    );

    modport slave (
        input  ex_write_back_enable, ex_destination, ex_result, ex_masked_write_back,
               ex_sew, ex_operand_3, wait_load_signal, load_destination, ld_valid, ld_data,
        output ex_stall, rf_we, rf_waddr, rf_wdata, rf_wsew, load_pending, err_protocol
    );
endinterface

// File: rtl/vwb.sv
// Vector-lane writeback: ALU-result FIFO, load tracker, WAW-ordered arbitration onto the RF write port.
// Define VWB_BYPASS_EN to let results skip the FIFO when nothing is queued or blocking.
module vwb #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input logic   clk,
    input logic   rst,
    vwb_if.slave  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] STALL_CNT = (PTR_W + 1)'(FIFO_DEPTH - 1);

    typedef enum logic {IDLE, PENDING} state_t;

    typedef struct packed {
        logic [4:0]            dest;
        logic [DATA_WIDTH-1:0] data;
        logic [2:0]            sew;
    } entry_t;

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    state_t           state;
    logic [4:0]       pend_dest;

    entry_t incoming;
    entry_t head;
    logic   fifo_empty;
    logic   fifo_full;
    logic   load_write;
    logic   head_block;
    logic   pop;
    logic   bypass;
    logic   push;
    logic   drop;

    always_comb begin
        incoming.dest = bus.ex_destination;
        incoming.data = bus.ex_masked_write_back ? bus.ex_operand_3 : bus.ex_result;
        incoming.sew  = bus.ex_sew;
    end

    assign head       = mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign load_write = (state == PENDING) && bus.ld_valid;
    // Younger results to the pending load's register must wait for the load to land.
    assign head_block = (state == PENDING) && (head.dest == pend_dest);
    assign pop        = !load_write && !fifo_empty && !head_block;

`ifdef VWB_BYPASS_EN
    logic in_block;
    assign in_block = (state == PENDING) && (incoming.dest == pend_dest);
    assign bypass   = bus.ex_write_back_enable && fifo_empty && !load_write && !in_block;
`else
    assign bypass   = 1'b0;
`endif

    // A pop on a full FIFO frees the slot the same cycle, so the push is accepted.
    assign push = bus.ex_write_back_enable && !bypass && (!fifo_full || pop);
    assign drop = bus.ex_write_back_enable && !bypass && fifo_full && !pop;

    assign bus.ex_stall = (count >= STALL_CNT);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= incoming;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            pend_dest        <= '0;
            bus.load_pending <= 1'b0;
            bus.err_protocol <= 1'b0;
            bus.rf_we        <= 1'b0;
            bus.rf_waddr     <= '0;
            bus.rf_wdata     <= '0;
            bus.rf_wsew      <= '0;
        end else begin
            bus.rf_we <= load_write || pop || bypass;
            if (load_write) begin
                bus.rf_waddr <= pend_dest;
                bus.rf_wdata <= bus.ld_data;
                bus.rf_wsew  <= 3'd3;
            end else if (pop) begin
                bus.rf_waddr <= head.dest;
                bus.rf_wdata <= head.data;
                bus.rf_wsew  <= head.sew;
            end else if (bypass) begin
                bus.rf_waddr <= incoming.dest;
                bus.rf_wdata <= incoming.data;
                bus.rf_wsew  <= incoming.sew;
            end

            unique case (state)
                IDLE: begin
                    if (bus.wait_load_signal) begin
                        state            <= PENDING;
                        pend_dest        <= bus.load_destination;
                        bus.load_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (bus.ld_valid) begin
                        if (bus.wait_load_signal) begin
                            pend_dest <= bus.load_destination;
                        end else begin
                            state            <= IDLE;
                            bus.load_pending <= 1'b0;
                        end
                    end
                end
            endcase

            if (drop
                || ((state == IDLE) && bus.ld_valid)
                || ((state == PENDING) && bus.wait_load_signal && !bus.ld_valid)) begin
                bus.err_protocol <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vwb.sv
// Randomized + directed bench for vwb against a queue-based reference model.
module tb_vwb;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
`ifdef VWB_BYPASS_EN
    localparam int ALU_LAT = 1;
`else
    localparam int ALU_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vwb_if #(.DATA_WIDTH(DW)) bus ();
    vwb #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [4:0]    dest;
        logic [DW-1:0] data;
        logic [2:0]    sew;
    } ent_t;

    ent_t     q[$];
    bit       pend;
    bit [4:0] pdest;
    bit       err;
    bit       exp_we;
    ent_t     exp_w;
    int       n_checks = 0;
    int       n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.ex_write_back_enable = 1'b0;
        bus.ex_destination       = '0;
        bus.ex_result            = '0;
        bus.ex_masked_write_back = 1'b0;
        bus.ex_sew               = '0;
        bus.ex_operand_3         = '0;
        bus.wait_load_signal     = 1'b0;
        bus.load_destination     = '0;
        bus.ld_valid             = 1'b0;
        bus.ld_data              = '0;
    endtask

    task automatic alu(input logic [4:0] d, input logic [63:0] r, input bit m, input logic [63:0] o3);
        bus.ex_write_back_enable = 1'b1;
        bus.ex_destination       = d;
        bus.ex_result            = r;
        bus.ex_masked_write_back = m;
        bus.ex_operand_3         = o3;
        bus.ex_sew               = 3'($urandom_range(0, 7));
    endtask

    // Apply the rules for the coming edge to the model, clock it, then compare.
    task automatic step();
        ent_t inc;
        bit   consumed;
        bit   was_rst;
        consumed = 0;
        was_rst  = rst;
        if (rst) begin
            q.delete();
            pend   = 0;
            pdest  = '0;
            err    = 0;
            exp_we = 0;
            exp_w  = '{dest: '0, data: '0, sew: '0};
        end else begin
            inc.dest = bus.ex_destination;
            inc.data = bus.ex_masked_write_back ? bus.ex_operand_3 : bus.ex_result;
            inc.sew  = bus.ex_sew;
            exp_we   = 1;
            if (pend && bus.ld_valid) begin
                exp_w = '{dest: pdest, data: bus.ld_data, sew: 3'd3};
            end else if (q.size() > 0 && !(pend && q[0].dest == pdest)) begin
                exp_w = q.pop_front();
`ifdef VWB_BYPASS_EN
            end else if (bus.ex_write_back_enable && q.size() == 0 && !(pend && inc.dest == pdest)) begin
                exp_w    = inc;
                consumed = 1;
`endif
            end else begin
                exp_we = 0;
            end
            if (bus.ex_write_back_enable && !consumed) begin
                if (q.size() < DEPTH) q.push_back(inc);
                else err = 1;
            end
            if (pend) begin
                if (bus.ld_valid) begin
                    pend = bus.wait_load_signal;
                    if (bus.wait_load_signal) pdest = bus.load_destination;
                end else if (bus.wait_load_signal) begin
                    err = 1;
                end
            end else begin
                if (bus.ld_valid) err = 1;
                if (bus.wait_load_signal) begin
                    pend  = 1;
                    pdest = bus.load_destination;
                end
            end
        end
        @(posedge clk);
        #1;
        check("rf_we", 64'(bus.rf_we), 64'(exp_we));
        if (exp_we || was_rst) begin
            check("rf_waddr", 64'(bus.rf_waddr), 64'(exp_w.dest));
            check("rf_wdata", bus.rf_wdata, exp_w.data);
            check("rf_wsew", 64'(bus.rf_wsew), 64'(exp_w.sew));
        end
        check("load_pending", 64'(bus.load_pending), 64'(pend));
        check("err_protocol", 64'(bus.err_protocol), 64'(err));
        check("ex_stall", 64'(bus.ex_stall), 64'(q.size() >= DEPTH - 1));
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        logic [63:0] got;
        idle();
        do_reset();

        // Single ALU result latency and value
        alu(5'd3, 64'hAA, 0, 64'h0);
        step();
        idle();
        lat = 1;
        while (!bus.rf_we && lat < 6) begin
            step();
            lat++;
        end
        check("t1_latency", 64'(lat), 64'(ALU_LAT));
        check("t1_waddr", 64'(bus.rf_waddr), 64'd3);
        check("t1_wdata", bus.rf_wdata, 64'hAA);
        repeat (2) step();

        // Masked write takes operand_3
        alu(5'd5, 64'h11, 1, 64'h22);
        step();
        idle();
        got = '0;
        if (bus.rf_we && bus.rf_waddr == 5'd5) got = bus.rf_wdata;
        repeat (3) begin
            step();
            if (bus.rf_we && bus.rf_waddr == 5'd5) got = bus.rf_wdata;
        end
        check("t2_masked", got, 64'h22);

        // WAW: load to v7 lands before the younger ALU result to v7
        bus.wait_load_signal = 1'b1;
        bus.load_destination = 5'd7;
        step();
        idle();
        alu(5'd7, 64'h55, 0, 64'h0);
        step();
        idle();
        step();
        step();
        check("t3_blocked", 64'(bus.rf_we), 64'd0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 64'h99;
        step();
        idle();
        check("t3_first", bus.rf_wdata, 64'h99);
        step();
        check("t3_second", bus.rf_wdata, 64'h55);
        check("t3_second_addr", 64'(bus.rf_waddr), 64'd7);
        step();

        // Load and ALU result compete for the port
        bus.wait_load_signal = 1'b1;
        bus.load_destination = 5'd9;
        step();
        idle();
        alu(5'd2, 64'h2, 0, 64'h0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 64'h77;
        step();
        idle();
        check("t4_load_first", 64'(bus.rf_waddr), 64'd9);
        step();
        check("t4_head_next", 64'(bus.rf_waddr), 64'd2);
        check("t4_head_data", bus.rf_wdata, 64'h2);
        step();

        // Fill while blocked, overflow sets the sticky error
        bus.wait_load_signal = 1'b1;
        bus.load_destination = 5'd1;
        step();
        for (int unsigned i = 0; i < 5; i++) begin
            idle();
            alu(5'd1, 64'(100 + i), 0, 64'h0);
            step();
            if (i == 1) check("t5_no_stall", 64'(bus.ex_stall), 64'd0);
            if (i == 2) check("t5_stall", 64'(bus.ex_stall), 64'd1);
            if (i == 3) check("t5_no_err", 64'(bus.err_protocol), 64'd0);
        end
        idle();
        check("t5_overflow_err", 64'(bus.err_protocol), 64'd1);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 64'h5;
        step();
        idle();
        repeat (6) step();
        do_reset();

        // Stray load data
        bus.ld_valid = 1'b1;
        bus.ld_data  = 64'h1234;
        step();
        idle();
        check("t6_no_we", 64'(bus.rf_we), 64'd0);
        check("t6_err", 64'(bus.err_protocol), 64'd1);
        do_reset();
        check("t6_err_cleared", 64'(bus.err_protocol), 64'd0);

        // Random traffic over a narrow register range to provoke WAW blocking
        for (int unsigned i = 0; i < 2000; i++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < ((q.size() >= DEPTH - 1) ? 5 : 55))
                alu(5'($urandom_range(0, 3)), {$urandom, $urandom}, bit'($urandom_range(0, 1)), {$urandom, $urandom});
            if (pend) begin
                bus.ld_valid = ($urandom_range(0, 99) < 30);
                bus.wait_load_signal = ($urandom_range(0, 99) < (bus.ld_valid ? 30 : 2));
            end else begin
                bus.ld_valid = ($urandom_range(0, 99) < 2);
                bus.wait_load_signal = ($urandom_range(0, 99) < 20);
            end
            bus.ld_data          = {$urandom, $urandom};
            bus.load_destination = 5'($urandom_range(0, 3));
            step();
        end
        rst = 1'b0;
        idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
